conv_tile_feeder: RTL and testbench

Upstream feeder for the convolution inner-loop stage. It accepts a row-major pixel stream and a serial weight stream. It assembles one tile per handshake: Pix centre pixels plus kx/2 east look-ahead pixels on `pixel_row`, and kx/2 west pixels on `west_paddings`, with zero padding at image edges. It holds the tile until the consumer reports completion, and presents the kx*kx kernel weights with a `weight_ready` qualifier.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_weight_loader.sv | 55 +++++
 rtl/conv_tile_feeder.sv | 151 +++++++++++++++
 tb/tb_conv_tile_feeder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution tile feeder.
//   feed_state_t   : feeder FSM state encoding
//   half_of()      : kernel half-width (kx/2), the west/east halo depth
//   tiles_per_row(): number of Pix-wide tiles across one image row
package conv_pkg;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_FILL,
        S_PRESENT
    } feed_state_t;

    function automatic int unsigned half_of(input int unsigned k);
        return k / 2;
    endfunction

    function automatic int unsigned tiles_per_row(input int unsigned img_w, input int unsigned pix);
        return img_w / pix;
    endfunction

endpackage

// File: rtl/conv_weight_loader.sv
// Serial-in kernel weight register.
//   clk, rst_n      : clock, asynchronous active-low reset
//   weight_i        : serial weight, index 0 first
//   w_valid_i       : weight_i valid
//   clear_i         : discard loaded weights and restart loading
//   hold_i          : tile being presented; clear_i is ignored while high
//   w_ready_o       : loader accepts weight_i (low once all weights are in)
//   weights_o       : kernel weights, index 0 = first weight received
//   weight_ready_o  : all KK weights loaded
module conv_weight_loader #(
    parameter int unsigned KK  = 9,
    parameter int unsigned RES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [RES-1:0]          weight_i,
    input  logic                    w_valid_i,
    input  logic                    clear_i,
    input  logic                    hold_i,
    output logic                    w_ready_o,
    output logic [KK-1:0][RES-1:0]  weights_o,
    output logic                    weight_ready_o
);

    localparam int unsigned IW = $clog2(KK);

    logic [KK-1:0][RES-1:0] weights_q;
    logic [IW-1:0]          widx_q;
    logic                   ready_q;

    // Gated by rst_n so the loader never advertises readiness while held in reset.
    assign w_ready_o      = rst_n && !ready_q;
    assign weights_o      = weights_q;
    assign weight_ready_o = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights_q <= '0;
            widx_q    <= '0;
            ready_q   <= 1'b0;
        end else if (clear_i && !hold_i) begin
            ready_q <= 1'b0;
            widx_q  <= '0;
        end else if (w_valid_i && !ready_q) begin
            weights_q[widx_q] <= weight_i;
            if (widx_q == IW'(KK - 1)) begin
                widx_q  <= '0;
                ready_q <= 1'b1;
            end else begin
                widx_q <= widx_q + IW'(1);
            end
        end
    end

endmodule

// File: rtl/conv_tile_feeder.sv
// Tile feeder for the convolution inner loop.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_pixel/in_valid : row-major pixel stream; in_ready accepts
//   in_weight/w_valid : serial kernel weights; w_ready accepts
//   weight_clear      : discard weights (ignored while a tile is presented)
//   tile_done         : consumer finished the presented tile
//   pixel_row         : columns c0 .. c0+Pix+HALF-1 of the current tile
//   west_paddings     : columns c0-HALF .. c0-1 (zero at the left edge)
//   pixel_ready       : tile valid and frozen until tile_done
//   weights           : kx*kx kernel weights, weight_ready when complete
//   tile_col, row_idx : position of the current tile
//   frame_done        : one-cycle pulse after the last tile of the frame
module conv_tile_feeder
    import conv_pkg::*;
#(
    parameter int unsigned kx    = 3,
    parameter int unsigned Pix   = 3,
    parameter int unsigned RES   = 8,
    parameter int unsigned IMG_W = 12,
    parameter int unsigned IMG_H = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [RES-1:0]                                in_pixel,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [RES-1:0]                                in_weight,
    input  logic                                          w_valid,
    output logic                                          w_ready,
    input  logic                                          weight_clear,
    input  logic                                          tile_done,
    output logic [Pix+half_of(kx)-1:0][RES-1:0]           pixel_row,
    output logic [half_of(kx)-1:0][RES-1:0]               west_paddings,
    output logic                                          pixel_ready,
    output logic [kx*kx-1:0][RES-1:0]                     weights,
    output logic                                          weight_ready,
    output logic [$clog2(tiles_per_row(IMG_W, Pix))-1:0]  tile_col,
    output logic [$clog2(IMG_H)-1:0]                      row_idx,
    output logic                                          frame_done
);

    localparam int unsigned HALF   = half_of(kx);
    localparam int unsigned WIN    = Pix + 2 * HALF;
    localparam int unsigned NTILES = tiles_per_row(IMG_W, Pix);
    localparam int unsigned TW     = $clog2(NTILES);
    localparam int unsigned RW     = $clog2(IMG_H);
    localparam int unsigned CW     = $clog2(IMG_W + HALF + 1);
    localparam int unsigned SW     = $clog2(Pix + HALF + 1);

    feed_state_t             state_q;
    logic [WIN-1:0][RES-1:0] win_q;
    logic [CW-1:0]           col_in_q;
    logic [SW-1:0]           slots_q;
    logic [TW-1:0]           tile_col_q;
    logic [RW-1:0]           row_idx_q;
    logic                    pixel_ready_q;
    logic                    frame_done_q;

    logic           col_live;
    logic           slot_adv;
    logic [RES-1:0] slot_pix;
    logic           last_tile;
    logic           last_row;

    // Columns past the right edge are zero padding and do not wait on the stream.
    assign col_live  = col_in_q < CW'(IMG_W);
    assign in_ready  = (state_q == S_FILL) && col_live;
    assign slot_adv  = (state_q == S_FILL) && (!col_live || in_valid);
    assign slot_pix  = col_live ? in_pixel : '0;
    assign last_tile = tile_col_q == TW'(NTILES - 1);
    assign last_row  = row_idx_q == RW'(IMG_H - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_CLEAR;
            win_q         <= '0;
            col_in_q      <= '0;
            slots_q       <= '0;
            tile_col_q    <= '0;
            row_idx_q     <= '0;
            pixel_ready_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                S_CLEAR: begin
                    win_q   <= '0;
                    slots_q <= SW'(Pix + HALF);
                    state_q <= S_FILL;
                end
                S_FILL: begin
                    if (slot_adv) begin
                        // Shift toward index 0; the newest column lands at the top.
                        win_q    <= {slot_pix, win_q[WIN-1:1]};
                        col_in_q <= col_in_q + CW'(1);
                        slots_q  <= slots_q - SW'(1);
                        if (slots_q == SW'(1)) begin
                            state_q       <= S_PRESENT;
                            pixel_ready_q <= 1'b1;
                        end
                    end
                end
                S_PRESENT: begin
                    if (tile_done) begin
                        pixel_ready_q <= 1'b0;
                        if (!last_tile) begin
                            // Window already holds the west halo and HALF look-ahead columns.
                            slots_q    <= SW'(Pix);
                            tile_col_q <= tile_col_q + TW'(1);
                            state_q    <= S_FILL;
                        end else begin
                            col_in_q   <= '0;
                            tile_col_q <= '0;
                            state_q    <= S_CLEAR;
                            if (last_row) begin
                                row_idx_q    <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                row_idx_q <= row_idx_q + RW'(1);
                            end
                        end
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign pixel_row     = win_q[WIN-1:HALF];
    assign west_paddings = win_q[HALF-1:0];
    assign pixel_ready   = pixel_ready_q;
    assign tile_col      = tile_col_q;
    assign row_idx       = row_idx_q;
    assign frame_done    = frame_done_q;

    conv_weight_loader #(
        .KK  (kx * kx),
        .RES (RES)
    ) u_weight_loader (
        .clk            (clk),
        .rst_n          (rst_n),
        .weight_i       (in_weight),
        .w_valid_i      (w_valid),
        .clear_i        (weight_clear),
        .hold_i         (pixel_ready_q),
        .w_ready_o      (w_ready),
        .weights_o      (weights),
        .weight_ready_o (weight_ready)
    );

endmodule

// File: tb/tb_conv_tile_feeder.sv
module tb_conv_tile_feeder;

    localparam int KX   = 3;
    localparam int PIX  = 3;
    localparam int RES  = 8;
    localparam int W    = 6;
    localparam int H    = 2;
    localparam int HALF = KX / 2;
    localparam int NT   = W / PIX;
    localparam int KK   = KX * KX;

    logic                            clk = 1'b0;
    logic                            rst_n = 1'b0;
    logic [RES-1:0]                  in_pixel = '0;
    logic                            in_valid = 1'b0;
    logic                            in_ready;
    logic [RES-1:0]                  in_weight = '0;
    logic                            w_valid = 1'b0;
    logic                            w_ready;
    logic                            weight_clear = 1'b0;
    logic                            tile_done = 1'b0;
    logic [PIX+HALF-1:0][RES-1:0]    pixel_row;
    logic [HALF-1:0][RES-1:0]        west_paddings;
    logic                            pixel_ready;
    logic [KK-1:0][RES-1:0]          weights;
    logic                            weight_ready;
    logic [$clog2(NT)-1:0]           tile_col;
    logic [$clog2(H)-1:0]            row_idx;
    logic                            frame_done;

    int vectors = 0;
    int miscompares = 0;

    // Reference image and the pixel stream still waiting to be accepted.
    logic [RES-1:0] img [H][W];
    logic [RES-1:0] stream_q [$];

    conv_tile_feeder #(
        .kx    (KX),
        .Pix   (PIX),
        .RES   (RES),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_pixel      (in_pixel),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_weight     (in_weight),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .weight_clear  (weight_clear),
        .tile_done     (tile_done),
        .pixel_row     (pixel_row),
        .west_paddings (west_paddings),
        .pixel_ready   (pixel_ready),
        .weights       (weights),
        .weight_ready  (weight_ready),
        .tile_col      (tile_col),
        .row_idx       (row_idx),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_frame(input bit seq);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                img[r][c] = seq ? RES'(r * W + c + 1) : RES'($urandom);
                stream_q.push_back(img[r][c]);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " pixel_ready"}, pixel_ready, 0);
        chk({tag, " weight_ready"}, weight_ready, 0);
        chk({tag, " frame_done"}, frame_done, 0);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " w_ready"}, w_ready, 0);
        chk({tag, " tile_col"}, tile_col, 0);
        chk({tag, " row_idx"}, row_idx, 0);
        chk({tag, " pixel_row"}, pixel_row, 0);
        chk({tag, " west"}, west_paddings, 0);
        chk({tag, " weights"}, weights, 0);
    endtask

    // Load KK weights with random w_valid gaps; values 1..KK or KK..1.
    task automatic load_weights(input bit rev);
        int n;
        int cyc;
        bit take;
        bit early;
        n = 0;
        cyc = 0;
        early = 0;
        while (n < KK && cyc < 500) begin
            w_valid = ($urandom_range(2) != 0);
            in_weight = rev ? RES'(KK - n) : RES'(n + 1);
            take = w_valid && w_ready;
            @(negedge clk);
            if (take) n++;
            if (n < KK && weight_ready !== 1'b0) early = 1;
            cyc++;
        end
        w_valid = 1'b0;
        chk("weight_ready early", early, 0);
        chk("weight_ready after load", weight_ready, 1);
        chk("w_ready after load", w_ready, 0);
        for (int i = 0; i < KK; i++)
            chk($sformatf("weights[%0d]", i), weights[i], rev ? KK - i : i + 1);
    endtask

    // stall: 0 none, 1 alternate cycles, 2 random. max_take 0 = fill whole tile.
    task automatic fill_tile(input int r, input int t, input int stall, input bit spurious,
                             input int max_take, output int consumed);
        int cyc;
        bit take;
        bit pos_ok;
        cyc = 0;
        pos_ok = 1;
        consumed = 0;
        while (pixel_ready !== 1'b1 && cyc < 200 && (max_take == 0 || consumed < max_take)) begin
            if (tile_col !== t[$bits(tile_col)-1:0] || row_idx !== r[$bits(row_idx)-1:0])
                pos_ok = 0;
            in_valid = (stream_q.size() > 0) &&
                       (stall == 0 || (stall == 1 && cyc[0]) ||
                        (stall == 2 && $urandom_range(99) >= 30));
            in_pixel = (stream_q.size() > 0) ? stream_q[0] : '0;
            tile_done = spurious ? 1'($urandom_range(1)) : 1'b0;
            take = in_valid && in_ready;
            @(negedge clk);
            if (take) begin
                void'(stream_q.pop_front());
                consumed++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tile_done = 1'b0;
        chk($sformatf("position during fill r%0d t%0d", r, t), pos_ok, 1);
        if (max_take == 0)
            chk($sformatf("pixel_ready rise r%0d t%0d", r, t), pixel_ready, 1);
    endtask

    task automatic present_tile(input int r, input int t, input int hold,
                                input bit clr_mid, input bit clr_same);
        logic [PIX+HALF-1:0][RES-1:0] row_s;
        logic [HALF-1:0][RES-1:0]     west_s;
        logic [RES-1:0]               e;
        int                           c;
        bit                           stable;
        bit                           ir_low;
        bit                           last;
        stable = 1;
        ir_low = 1;
        last = (r == H - 1) && (t == NT - 1);
        chk($sformatf("tile_col r%0d t%0d", r, t), tile_col, t);
        chk($sformatf("row_idx r%0d t%0d", r, t), row_idx, r);
        chk($sformatf("weight_ready at present r%0d t%0d", r, t), weight_ready, 1);
        for (int i = 0; i < PIX + HALF; i++) begin
            c = t * PIX + i;
            e = (c < W) ? img[r][c] : '0;
            chk($sformatf("pixel_row r%0d t%0d i%0d", r, t, i), pixel_row[i], e);
        end
        for (int j = 0; j < HALF; j++) begin
            c = t * PIX - HALF + j;
            e = (c >= 0) ? img[r][c] : '0;
            chk($sformatf("west r%0d t%0d j%0d", r, t, j), west_paddings[j], e);
        end
        row_s = pixel_row;
        west_s = west_paddings;
        for (int k = 0; k < hold; k++) begin
            weight_clear = clr_mid && (k == hold / 2);
            in_valid = (stream_q.size() > 0) && k[0];
            in_pixel = (stream_q.size() > 0) ? stream_q[0] : '0;
            @(negedge clk);
            weight_clear = 1'b0;
            if (pixel_row !== row_s || west_paddings !== west_s || pixel_ready !== 1'b1
                || frame_done !== 1'b0)
                stable = 0;
            if (in_ready !== 1'b0) ir_low = 0;
        end
        in_valid = 1'b0;
        chk($sformatf("tile stable r%0d t%0d", r, t), stable, 1);
        chk($sformatf("in_ready low in present r%0d t%0d", r, t), ir_low, 1);
        if (clr_mid) chk("weight_clear ignored in present", weight_ready, 1);
        tile_done = 1'b1;
        weight_clear = clr_same;
        @(negedge clk);
        tile_done = 1'b0;
        weight_clear = 1'b0;
        chk($sformatf("pixel_ready fall r%0d t%0d", r, t), pixel_ready, 0);
        chk($sformatf("frame_done r%0d t%0d", r, t), frame_done, last);
        if (clr_same) chk("weight_clear with tile_done ignored", weight_ready, 1);
        if (last) begin
            @(negedge clk);
            chk("frame_done one cycle", frame_done, 0);
            chk("row_idx wrap", row_idx, 0);
        end
    endtask

    task automatic run_frame(input int stall, input int hold, input bit spurious,
                             input bit clr_tests);
        int cons;
        int lo;
        int hi;
        for (int r = 0; r < H; r++) begin
            for (int t = 0; t < NT; t++) begin
                fill_tile(r, t, stall, spurious, 0, cons);
                // Stream columns newly covered by this tile, capped at the image edge.
                lo = (t == 0) ? 0 : t * PIX + HALF;
                hi = ((t + 1) * PIX + HALF < W) ? (t + 1) * PIX + HALF : W;
                chk($sformatf("pixels consumed r%0d t%0d", r, t), cons, hi - lo);
                present_tile(r, t, hold, clr_tests && r == 0 && t == 1,
                             clr_tests && r == 1 && t == 0);
            end
        end
    endtask

    initial begin
        int cons;

        // Reset state.
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic row and frame wrap with sequential pixels, weights 1..9.
        load_weights(1'b0);
        new_frame(1'b1);
        run_frame(0, 4, 1'b0, 1'b0);

        // Back-pressure, long hold, weight_clear during present.
        new_frame(1'b0);
        run_frame(1, 20, 1'b0, 1'b1);

        // weight_clear while idle, then reload reversed.
        weight_clear = 1'b1;
        @(negedge clk);
        weight_clear = 1'b0;
        chk("weight_clear idle drops ready", weight_ready, 0);
        chk("w_ready after idle clear", w_ready, 1);
        load_weights(1'b1);

        // Random stalls with spurious tile_done during fill.
        new_frame(1'b0);
        run_frame(2, 3, 1'b1, 1'b0);

        // Reset after two pixels of tile 0.
        new_frame(1'b0);
        fill_tile(0, 0, 0, 1'b0, 2, cons);
        chk("pixels before mid-tile reset", cons, 2);
        rst_n = 1'b0;
        #1;
        check_zero("mid-tile reset");
        @(negedge clk);
        rst_n = 1'b1;
        stream_q.delete();
        @(negedge clk);
        load_weights(1'b0);
        new_frame(1'b0);
        run_frame(2, 2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
